set_job_arbiter: RTL

Shares one SET circle-set-count core between two independent job requesters. Each job is a 24-bit central vector, a 12-bit radius vector and a 2-bit mode. The block arbitrates round-robin, issues one job at a time to the core with a single-cycle enable, waits for the core's valid, and returns the candidate count tagged with the requester id. It sits between the job sources and the SET core, and it is the only driver of the core's `en`/`central`/`radius`/`mode` inputs.

---
 rtl/set_job_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/set_job_arbiter.sv
// Round-robin arbiter that shares one SET circle-set-count core between two job requesters.
// Optional per-job watchdog is compiled in with `define SET_ARB_WDOG_EN.
module set_job_arbiter #(
    parameter int unsigned WDOG_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] central0,
    input  logic [23:0] central1,
    input  logic [11:0] radius0,
    input  logic [11:0] radius1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        core_en,
    output logic [23:0] core_central,
    output logic [11:0] core_radius,
    output logic [1:0]  core_mode,
    input  logic        core_busy,
    input  logic        core_valid,
    input  logic [7:0]  core_candidate,
    output logic        res_valid,
    output logic        res_id,
    output logic [7:0]  res_candidate,
    output logic        res_timeout,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [23:0] central_q, central_d;
    logic [11:0] radius_q, radius_d;
    logic [1:0]  mode_q, mode_d;
    logic        res_id_q, res_id_d;
    logic [7:0]  res_cand_q, res_cand_d;
    logic        win_id;
    logic        take;

    // A held req is accepted by its one-cycle gnt (same cycle as core_en); results are
    // one-cycle res_valid strobes with no back-pressure, and core_valid counts only in WAIT.
    assign win_id = (req0 && req1) ? ~last_q : req1;
    assign take   = (req0 || req1) && !core_busy;

`ifdef SET_ARB_WDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        tout_q, tout_d;
    logic        wdog_hit;

    assign wdog_hit = ({1'b0, wdog_q} + 17'd1) == 17'(WDOG_CYC);
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYC == 0);
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        res_id_d   = res_id_q;
        res_cand_d = res_cand_q;
`ifdef SET_ARB_WDOG_EN
        wdog_d     = wdog_q;
        tout_d     = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d   = ISSUE;
                    last_d    = win_id;
                    central_d = win_id ? central1 : central0;
                    radius_d  = win_id ? radius1 : radius0;
                    mode_d    = win_id ? mode1 : mode0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SET_ARB_WDOG_EN
                wdog_d  = 16'd0;
`endif
            end
            WAIT: begin
                if (core_valid) begin
                    state_d    = RESP;
                    res_id_d   = last_q;
                    res_cand_d = core_candidate;
`ifdef SET_ARB_WDOG_EN
                    tout_d     = 1'b0;
                end else if (wdog_hit) begin
                    state_d    = RESP;
                    res_id_d   = last_q;
                    res_cand_d = 8'd0;
                    tout_d     = 1'b1;
                end else begin
                    wdog_d     = wdog_q + 16'd1;
`endif
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            central_q  <= '0;
            radius_q   <= '0;
            mode_q     <= '0;
            res_id_q   <= 1'b0;
            res_cand_q <= '0;
`ifdef SET_ARB_WDOG_EN
            wdog_q     <= '0;
            tout_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            res_id_q   <= res_id_d;
            res_cand_q <= res_cand_d;
`ifdef SET_ARB_WDOG_EN
            wdog_q     <= wdog_d;
            tout_q     <= tout_d;
`endif
        end
    end

    // last_q already names the owner of the job in flight, so it drives the grant lines.
    assign core_en       = (state_q == ISSUE);
    assign gnt0          = (state_q == ISSUE) && !last_q;
    assign gnt1          = (state_q == ISSUE) && last_q;
    assign core_central  = central_q;
    assign core_radius   = radius_q;
    assign core_mode     = mode_q;
    assign res_valid     = (state_q == RESP);
    assign res_id        = res_id_q;
    assign res_candidate = res_cand_q;
    assign dbg_state_o   = state_q;
`ifdef SET_ARB_WDOG_EN
    assign res_timeout   = (state_q == RESP) && tout_q;
`else
    assign res_timeout   = 1'b0;
`endif

endmodule
